// File: rtl/div_share_sched.sv
// div_share_sched: round-robin sharing of one fixed-latency pipelined divider.
// Tags each issue with owner and divide-by-zero, then routes results back.
module div_share_sched #(
    parameter int NREQ = 4,
    parameter int N    = 5,
    parameter int M    = 3,
    parameter int LAT  = 5,
    parameter int TW   = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_dividend,
    input  logic [NREQ*M-1:0] req_divisor,
    output logic              div_en,
    output logic [N-1:0]      div_dividend,
    output logic [M-1:0]      div_divisor,
    input  logic              div_res_rdy,
    input  logic [M-1:0]      div_merchant,
    input  logic [M-1:0]      div_remainder,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [M-1:0]      rsp_merchant,
    output logic [M-1:0]      rsp_remainder,
    output logic              rsp_dz,
    output logic              busy,
    output logic              err
);

    localparam int CW = $clog2(LAT + 3);

    logic [TW-1:0]         ptr_q, ptr_d;
    logic                  gnt_vld;
    logic [TW-1:0]         gnt_idx;
    logic [NREQ-1:0]       gnt_oh;
    logic                  xfer;
    logic [NREQ*N-1:0]     dvd_sh;
    logic [NREQ*M-1:0]     dsr_sh;
    logic [N-1:0]          sel_dvd;
    logic [M-1:0]          sel_dsr;

    logic                  en_q, en_d;
    logic [N-1:0]          dvd_q, dvd_d;
    logic [M-1:0]          dsr_q, dsr_d;

    logic [LAT:0]          pv_q, pv_d;
    logic [LAT:0][TW-1:0]  ptag_q, ptag_d;
    logic [LAT:0]          pdz_q, pdz_d;

    logic                  hit;
    logic [NREQ-1:0]       rv_q, rv_d;
    logic [M-1:0]          rm_q, rm_d;
    logic [M-1:0]          rr_q, rr_d;
    logic                  rdz_q, rdz_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;

    // Search starts one past the last winner and wraps.
    always_comb begin
        int j;
        logic [NREQ-1:0] rv_sh;
        j       = 0;
        rv_sh   = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j     = (int'(ptr_q) + k) % NREQ;
            rv_sh = req_valid >> j;
            if (!gnt_vld && rv_sh[0]) begin
                gnt_vld = 1'b1;
                gnt_idx = TW'(j);
            end
        end
    end

    assign gnt_oh  = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    assign xfer    = |(req_valid & gnt_oh);
    assign dvd_sh  = req_dividend >> (int'(gnt_idx) * N);
    assign dsr_sh  = req_divisor >> (int'(gnt_idx) * M);
    assign sel_dvd = dvd_sh[N-1:0];
    assign sel_dsr = dsr_sh[M-1:0];

    always_comb begin
        ptr_d  = xfer ? gnt_idx : ptr_q;
        en_d   = xfer;
        dvd_d  = xfer ? sel_dvd : dvd_q;
        dsr_d  = xfer ? sel_dsr : dsr_q;
        pv_d   = {pv_q[LAT-1:0], xfer};
        ptag_d = {ptag_q[LAT-1:0], gnt_idx};
        pdz_d  = {pdz_q[LAT-1:0], xfer && (sel_dsr == '0)};
    end

    // The tag head and the divider strobe must agree every cycle.
    assign hit = pv_q[LAT] && div_res_rdy;

    always_comb begin
        err_d = err_q | (pv_q[LAT] != div_res_rdy);
        rv_d  = hit ? (NREQ'(1) << ptag_q[LAT]) : '0;
        rm_d  = hit ? div_merchant : rm_q;
        rr_d  = hit ? div_remainder : rr_q;
        rdz_d = hit ? pdz_q[LAT] : rdz_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({xfer, hit})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q  <= TW'(NREQ - 1);
            en_q   <= 1'b0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            pv_q   <= '0;
            ptag_q <= '0;
            pdz_q  <= '0;
            rv_q   <= '0;
            rm_q   <= '0;
            rr_q   <= '0;
            rdz_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            en_q   <= en_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            pv_q   <= pv_d;
            ptag_q <= ptag_d;
            pdz_q  <= pdz_d;
            rv_q   <= rv_d;
            rm_q   <= rm_d;
            rr_q   <= rr_d;
            rdz_q  <= rdz_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign req_ready     = gnt_oh;
    assign div_en        = en_q;
    assign div_dividend  = dvd_q;
    assign div_divisor   = dsr_q;
    assign rsp_valid     = rv_q;
    assign rsp_merchant  = rm_q;
    assign rsp_remainder = rr_q;
    assign rsp_dz        = rdz_q;
    assign busy          = (cnt_q != '0) || en_q;
    assign err           = err_q;

endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: randomized and directed checks of the divider sharer
// against a transaction-level reference model and a behavioural divider.
module tb_div_share_sched;

    localparam int NREQ = 4;
    localparam int N    = 5;
    localparam int M    = 3;
    localparam int LAT  = 5;
    localparam int TW   = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_dividend = '0;
    logic [NREQ*M-1:0] req_divisor = '0;
    logic              div_en;
    logic [N-1:0]      div_dividend;
    logic [M-1:0]      div_divisor;
    logic              div_res_rdy;
    logic [M-1:0]      div_merchant;
    logic [M-1:0]      div_remainder;
    logic [NREQ-1:0]   rsp_valid;
    logic [M-1:0]      rsp_merchant;
    logic [M-1:0]      rsp_remainder;
    logic              rsp_dz;
    logic              busy;
    logic              err;
    logic              force_rdy = 1'b0;

    always #5 clk = ~clk;

    div_share_sched #(
        .NREQ(NREQ), .N(N), .M(M), .LAT(LAT), .TW(TW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_en(div_en), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_res_rdy(div_res_rdy),
        .div_merchant(div_merchant), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_merchant(rsp_merchant),
        .rsp_remainder(rsp_remainder), .rsp_dz(rsp_dz),
        .busy(busy), .err(err)
    );

    // Behavioural divider: LAT cycles from enable to result strobe
    logic         den [LAT];
    logic [M-1:0] dq  [LAT];
    logic [M-1:0] dr  [LAT];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                den[i] <= 1'b0;
                dq[i]  <= '0;
                dr[i]  <= '0;
            end
        end else begin
            den[0] <= div_en;
            dq[0]  <= (div_divisor == '0) ? '0 :
                      M'(int'(div_dividend) / int'(div_divisor));
            dr[0]  <= (div_divisor == '0) ? '0 :
                      M'(int'(div_dividend) % int'(div_divisor));
            for (int i = 1; i < LAT; i++) begin
                den[i] <= den[i-1];
                dq[i]  <= dq[i-1];
                dr[i]  <= dr[i-1];
            end
        end
    end

    assign div_res_rdy   = den[LAT-1] | force_rdy;
    assign div_merchant  = dq[LAT-1];
    assign div_remainder = dr[LAT-1];

    typedef struct {
        int req;
        int a;
        int b;
        int iss;
        int due;
    } exp_t;

    exp_t         sbq[$];
    int           glog[$];
    int           ptr;
    int           cyc = 0;
    int           ncmp = 0;
    int           nerr = 0;
    bit           pend [NREQ];
    logic [N-1:0] oa [NREQ];
    logic [M-1:0] ob [NREQ];
    bit           rearm = 1'b0;
    bit           rmode = 1'b0;
    bit           exp_err = 1'b0;
    bit           frc_next = 1'b0;

    task automatic new_ops(input int i);
        oa[i] = N'($urandom_range(0, (1 << N) - 1));
        ob[i] = M'($urandom_range(rmode ? 0 : 1, (1 << M) - 1));
    endtask

    task automatic step();
        int g;
        int j;
        logic [NREQ-1:0] ev;
        bit en_exp;
        bit bz_exp;
        int ea;
        int eb;
        exp_t e;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = pend[i];
            req_dividend[i*N +: N] = oa[i];
            req_divisor[i*M +: M]  = ob[i];
        end
        force_rdy = frc_next;
        frc_next  = 1'b0;
        #1;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (ptr + k) % NREQ;
            if (g < 0 && pend[j]) g = j;
        end
        ev = (g >= 0) ? NREQ'(1) << g : '0;
        ncmp++;
        if (req_ready !== ev) begin
            nerr++;
            $display("FAIL req_ready cyc %0d: got %b expected %b", cyc, req_ready, ev);
        end
        en_exp = 1'b0;
        bz_exp = 1'b0;
        ea = 0;
        eb = 0;
        foreach (sbq[k]) begin
            if (sbq[k].iss == cyc - 1) begin
                en_exp = 1'b1;
                ea = sbq[k].a;
                eb = sbq[k].b;
            end
            if (sbq[k].iss < cyc && cyc < sbq[k].due) bz_exp = 1'b1;
        end
        ncmp++;
        if (div_en !== en_exp) begin
            nerr++;
            $display("FAIL div_en cyc %0d: got %b expected %b", cyc, div_en, en_exp);
        end
        if (en_exp) begin
            ncmp++;
            if (div_dividend !== N'(ea) || div_divisor !== M'(eb)) begin
                nerr++;
                $display("FAIL operands cyc %0d: got %0d/%0d expected %0d/%0d",
                         cyc, div_dividend, div_divisor, ea, eb);
            end
        end
        ncmp++;
        if (busy !== bz_exp) begin
            nerr++;
            $display("FAIL busy cyc %0d: got %b expected %b", cyc, busy, bz_exp);
        end
        ncmp++;
        if (err !== exp_err) begin
            nerr++;
            $display("FAIL err cyc %0d: got %b expected %b", cyc, err, exp_err);
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            ev = NREQ'(1) << e.req;
            ncmp++;
            if (rsp_valid !== ev || rsp_dz !== (e.b == 0)) begin
                nerr++;
                $display("FAIL rsp cyc %0d: got valid %b dz %b expected valid %b dz %b",
                         cyc, rsp_valid, rsp_dz, ev, e.b == 0);
            end
            if (e.b != 0) begin
                ncmp++;
                if (rsp_merchant !== M'(e.a / e.b) || rsp_remainder !== M'(e.a % e.b)) begin
                    nerr++;
                    $display("FAIL rsp_data cyc %0d: got q%0d r%0d expected q%0d r%0d",
                             cyc, rsp_merchant, rsp_remainder,
                             M'(e.a / e.b), M'(e.a % e.b));
                end
            end
        end else begin
            ncmp++;
            if (rsp_valid !== '0) begin
                nerr++;
                $display("FAIL rsp_idle cyc %0d: got %b expected 0", cyc, rsp_valid);
            end
        end
        if (g >= 0) begin
            e.req = g;
            e.a   = int'(oa[g]);
            e.b   = int'(ob[g]);
            e.iss = cyc;
            e.due = cyc + LAT + 2;
            sbq.push_back(e);
            glog.push_back(g);
            ptr = g;
            pend[g] = 1'b0;
            if (rearm) begin
                pend[g] = 1'b1;
                new_ops(g);
            end
        end
        if (rmode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    new_ops(i);
                end
            end
        end
    endtask

    task automatic drain();
        repeat (NREQ + LAT + 4) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        req_valid = '0;
        force_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ptr = NREQ - 1;
        sbq.delete();
        glog.delete();
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        #1;
        ncmp++;
        if ({req_ready, div_en, div_dividend, div_divisor, rsp_valid,
             rsp_merchant, rsp_remainder, rsp_dz, busy, err} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got rdy %b en %b rsp %b busy %b err %b expected all 0",
                     req_ready, div_en, rsp_valid, busy, err);
        end
    endtask

    task automatic test_single();
        do_reset();
        pend[2] = 1'b1;
        oa[2]   = N'(22);
        ob[2]   = M'(5);
        drain();
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1;
            new_ops(i);
        end
        rearm = 1'b1;
        repeat (8) step();
        rearm = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drain();
        for (int i = 0; i < 8; i++) begin
            ncmp++;
            if (glog.size() <= i || glog[i] != i % NREQ) begin
                nerr++;
                $display("FAIL rr_order idx %0d: got %0d expected %0d", i,
                         (glog.size() > i) ? glog[i] : -1, i % NREQ);
            end
        end
    endtask

    task automatic test_dz();
        do_reset();
        pend[1] = 1'b1;
        oa[1]   = N'(9);
        ob[1]   = M'(0);
        drain();
    endtask

    task automatic test_wrap();
        int wexp[3] = '{3, 0, 3};
        do_reset();
        pend[3] = 1'b1;
        new_ops(3);
        step();
        pend[0] = 1'b1;
        pend[3] = 1'b1;
        new_ops(0);
        new_ops(3);
        drain();
        for (int i = 0; i < 3; i++) begin
            ncmp++;
            if (glog.size() <= i || glog[i] != wexp[i]) begin
                nerr++;
                $display("FAIL wrap idx %0d: got %0d expected %0d", i,
                         (glog.size() > i) ? glog[i] : -1, wexp[i]);
            end
        end
    endtask

    task automatic test_err();
        do_reset();
        step();
        step();
        frc_next = 1'b1;
        step();
        exp_err = 1'b1;
        repeat (4) step();
        do_reset();
        @(negedge clk);
        #1;
        ncmp++;
        if (err !== 1'b0) begin
            nerr++;
            $display("FAIL err_cleared: got %b expected 0", err);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b1;
            new_ops(i);
        end
        repeat (4) step();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        ncmp++;
        if (busy !== 1'b0 || rsp_valid !== '0 || div_en !== 1'b0) begin
            nerr++;
            $display("FAIL mid_reset: got busy %b rsp %b en %b expected 0",
                     busy, rsp_valid, div_en);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ptr = NREQ - 1;
        sbq.delete();
        glog.delete();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drain();
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1;
            new_ops(i);
        end
        drain();
        ncmp++;
        if (glog.size() == 0 || glog[0] != 0) begin
            nerr++;
            $display("FAIL restart_ptr: got %0d expected 0",
                     (glog.size() > 0) ? glog[0] : -1);
        end
    endtask

    task automatic test_random();
        do_reset();
        rmode = 1'b1;
        repeat (300) step();
        rmode = 1'b0;
        drain();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            oa[i]   = '0;
            ob[i]   = '0;
        end
        ptr = NREQ - 1;
        test_reset();
        test_single();
        test_all_four();
        test_dz();
        test_wrap();
        test_err();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
